xor_stream_cipher: RTL and testbench
====================================

XOR_STREAM_CIPHER -- requirements
Module: xor_stream_cipher

Interface
REQ-001 Parameter KEY_BITS, default 32: key length in bits; SHALL be a multiple of DATA_W.
REQ-002 Parameter DATA_W, default 1: bits per beat on the data input and output; 1, 2, 4 or 8.
REQ-003 Parameter MAX_MSG_BITS, default 512: maximum message length in bits; SHALL be a multiple of DATA_W. MAX_BEATS = MAX_MSG_BITS/DATA_W.
REQ-004 Ports SHALL be:
- iClk  in  1  sole clock; all logic on the rising edge.
- iRst  in  1  synchronous reset, active-high.
- iEn  in  1  global enable.
- iMode  in  1  keystream mode: 0 = repeating key, 1 = rolling key.
- iData_in  in  DATA_W  serial key or message beat.
- iLoad_key  in  1  key-load strobe.
- iLoad_msg  in  1  message strobe.
- oData_out  out  DATA_W  ciphertext beat.
- oValid  out  1  oData_out is valid.
- oStart  out  1  first ciphertext beat of a message.
- oEnd  out  1  last ciphertext beat of a message.
- oKey_ready  out  1  complete key held.
- oBusy  out  1  message in progress or pipeline not empty.

Function
REQ-005 State machine states: IDLE, LOAD_KEY, READY, STREAM, DRAIN. Reset state is IDLE.
REQ-006 Key load behaviour:
- Each cycle with iEn=1 and iLoad_key=1, key_reg shifts left by DATA_W bits, with iData_in entering at the LSBs (MSB-first).
- The beat counter increments on each such beat.
- This applies in IDLE, LOAD_KEY and READY; a beat in READY clears oKey_ready and counts as beat 1 of a new key.
REQ-007 Key completion: on beat KEY_BITS/DATA_W, the FSM enters READY and sets oKey_ready=1 on the following cycle.
REQ-008 Partial key load: if iLoad_key drops before the key is complete, LOAD_KEY and the beat count are held, and loading resumes when iLoad_key returns.
REQ-009 Message start: in READY, a beat with iEn=1, iLoad_msg=1 and iLoad_key=0 enters STREAM, copies key_reg to work_key, and sets key slice index 0.
REQ-010 Per-message beat processing: each message beat computes ct = iData_in XOR work_key[KEY_BITS-1-idx*DATA_W -: DATA_W], where idx is the current key slice index.
REQ-011 Slice index wrap: idx increments per beat and wraps to 0 after KEY_BITS/DATA_W-1.
- iMode=1 only: on each wrap, work_key rotates left by 1 bit.
- iMode is sampled at message start and held for the message.
REQ-012 Latency: exactly 2 cycles from an input beat to its oValid=1 output; beats emerge in order and gaps are preserved.
REQ-013 oStart=1 together with the first output beat of a message only.
REQ-014 oEnd=1 together with the last output beat of a message. The last beat is:
- the beat followed by iLoad_msg=0, or
- beat MAX_BEATS, or
- the beat followed by an iLoad_key assertion.
REQ-015 Single-beat message: oStart=oEnd=1 on the same output beat.
REQ-016 Length limit: after beat MAX_BEATS the FSM enters DRAIN, ignores input until iLoad_msg=0, then returns to READY.
REQ-017 Key load during STREAM:
- iLoad_key=1 during STREAM terminates the message, with oEnd on the prior beat.
- The beat is consumed as key beat 1, and the FSM enters LOAD_KEY.
REQ-018 Simultaneous iLoad_key=1 and iLoad_msg=1: the key wins and the message beat is discarded.
REQ-019 iLoad_msg in IDLE or LOAD_KEY is ignored and produces no output.
REQ-020 key_reg is never modified by streaming; consecutive messages each restart at idx 0 with the loaded key.
REQ-021 iEn=0 freezes all state, counters and pipeline contents, and forces oValid, oStart and oEnd to 0; held beats resume output when iEn=1.
REQ-022 oBusy=1 whenever the state is STREAM or DRAIN or any pipeline stage holds a valid beat.

Reset
REQ-023 iRst=1 at a clock edge, including mid-key-load and mid-message, SHALL:
- set state IDLE,
- clear key_reg, work_key, idx, beat counters and pipeline valids,
- drive oData_out=0, oValid=0, oStart=0, oEnd=0, oKey_ready=0, oBusy=0 on the next cycle.
iRst takes precedence over iEn.
REQ-024 No output beat belonging to a message interrupted by reset SHALL appear after reset.

Verification
Parameters for all scenarios: KEY_BITS=32, DATA_W=8, MAX_MSG_BITS=64.
REQ-025 Basic encrypt:
- Stimulus: key bytes A5,5A,0F,F0; message 00,FF,00,FF,11 with iMode=0.
- Response: outputs A5,A5,0F,0F,B4, each 2 cycles after its input; oStart on A5 (first), oEnd on B4.
REQ-026 Rolling key:
- Stimulus: same key; 8 bytes of 00 with iMode=1.
- Response: A5,5A,0F,F0 then 4A,B4,1F,E1; beat 8 is the length limit (MAX_BEATS=8), so oEnd=1 on E1.
REQ-027 Length limit:
- Stimulus: iLoad_msg held for 12 beats.
- Response: exactly 8 outputs, oEnd on the 8th, oBusy=1 until iLoad_msg falls and the pipeline drains.
REQ-028 Key collision:
- Stimulus: iLoad_key raised at message beat 3, with iLoad_msg still high.
- Response: oEnd on output beat 2; oKey_ready=0; a new key completes after 4 beats.
REQ-029 Disable and reset:
- Stimulus: iEn=0 for 3 cycles mid-message.
- Response: outputs pause with values unchanged when resumed.
- Stimulus: iRst=1 mid-message.
- Response: all outputs 0 the next cycle; a following iLoad_msg with no key produces no output.

Source files
------------

// File: rtl/xor_stream_cipher.sv
// XOR stream cipher: serially loads a key, then XORs message beats against
// successive key slices. Repeating or rolling keystream, two-stage output
// pipeline with start/end framing.
module xor_stream_cipher #(
   parameter int KEY_BITS     = 32,
   parameter int DATA_W       = 1,
   parameter int MAX_MSG_BITS = 512
) (
   input  logic              iClk,
   input  logic              iRst,
   input  logic              iEn,
   input  logic              iMode,
   input  logic [DATA_W-1:0] iData_in,
   input  logic              iLoad_key,
   input  logic              iLoad_msg,
   output logic [DATA_W-1:0] oData_out,
   output logic              oValid,
   output logic              oStart,
   output logic              oEnd,
   output logic              oKey_ready,
   output logic              oBusy
);

   localparam int KEY_BEATS = KEY_BITS / DATA_W;
   localparam int MAX_BEATS = MAX_MSG_BITS / DATA_W;
   localparam int KCNT_W    = $clog2(KEY_BEATS + 1);
   localparam int MCNT_W    = $clog2(MAX_BEATS + 1);
   localparam int IDX_W     = (KEY_BEATS > 1) ? $clog2(KEY_BEATS) : 1;

   typedef enum logic [2:0] {IDLE, LOAD_KEY, READY, STREAM, DRAIN} state_t;

   typedef struct packed {
      logic              valid;
      logic              first;
      logic              last;
      logic [DATA_W-1:0] data;
   } beat_t;

   state_t              state, state_nx;
   logic [KEY_BITS-1:0] key_reg, key_reg_nx;
   logic [KEY_BITS-1:0] work_key, work_key_nx;
   logic [KCNT_W-1:0]   key_cnt, key_cnt_nx, key_cnt_new;
   logic [MCNT_W-1:0]   msg_cnt, msg_cnt_nx, msg_cnt_new;
   logic [IDX_W-1:0]    idx, idx_nx;
   logic                mode_q, mode_nx;
   logic                key_ready, key_ready_nx;
   beat_t               s1, s1_nx, s2, s2_nx;

   logic                key_beat, msg_first, msg_beat, end_prev, wrap, cur_mode;
   logic [KEY_BITS-1:0] cur_key, shifted;
   logic [IDX_W-1:0]    cur_idx;

   // Next-state, key/work-key update and pipeline advance for one enabled beat.
   always_comb begin
      // NOTE: every variable gets a default here first so no path infers a latch.
      state_nx     = state;
      key_reg_nx   = key_reg;
      work_key_nx  = work_key;
      key_cnt_nx   = key_cnt;
      msg_cnt_nx   = msg_cnt;
      idx_nx       = idx;
      mode_nx      = mode_q;
      key_ready_nx = key_ready;

      // Key beats are honoured everywhere except while draining an over-long message.
      key_beat  = iLoad_key && (state != DRAIN);
      msg_first = (state == READY) && iLoad_msg && !iLoad_key;
      msg_beat  = msg_first || ((state == STREAM) && iLoad_msg && !iLoad_key);
      // The beat in stage 1 is the last one if streaming stops this cycle.
      end_prev  = (state == STREAM) && (!iLoad_msg || iLoad_key);

      // A new message starts from the loaded key at slice 0 with the current mode.
      cur_key  = msg_first ? key_reg : work_key;
      cur_idx  = msg_first ? '0 : idx;
      cur_mode = msg_first ? iMode : mode_q;
      wrap     = (cur_idx == IDX_W'(KEY_BEATS - 1));
      shifted  = cur_key << (int'(cur_idx) * DATA_W);

      key_cnt_new = (state == READY || state == STREAM) ? KCNT_W'(1) : key_cnt + KCNT_W'(1);
      msg_cnt_new = msg_first ? MCNT_W'(1) : msg_cnt + MCNT_W'(1);

      s2_nx      = s1;
      s2_nx.last = s1.last | (s1.valid & end_prev);
      s1_nx      = '0;

      if (key_beat) begin
         key_reg_nx = (key_reg << DATA_W) | KEY_BITS'(iData_in);
         if (key_cnt_new == KCNT_W'(KEY_BEATS)) begin
            state_nx     = READY;
            key_ready_nx = 1'b1;
            key_cnt_nx   = '0;
         end else begin
            state_nx     = LOAD_KEY;
            key_ready_nx = 1'b0;
            key_cnt_nx   = key_cnt_new;
         end
      end else if (msg_beat) begin
         s1_nx.valid = 1'b1;
         s1_nx.first = msg_first;
         s1_nx.last  = (msg_cnt_new == MCNT_W'(MAX_BEATS));
         s1_nx.data  = iData_in ^ shifted[KEY_BITS-1 -: DATA_W];
         msg_cnt_nx  = msg_cnt_new;
         idx_nx      = wrap ? '0 : cur_idx + IDX_W'(1);
         work_key_nx = (cur_mode && wrap) ? {cur_key[KEY_BITS-2:0], cur_key[KEY_BITS-1]} : cur_key;
         mode_nx     = cur_mode;
         state_nx    = s1_nx.last ? DRAIN : STREAM;
      end else if (state == STREAM) begin
         state_nx = READY;
      end else if (state == DRAIN && !iLoad_msg) begin
         state_nx = READY;
      end
   end

   // State and pipeline registers: synchronous reset wins, iEn=0 freezes everything.
   always_ff @(posedge iClk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (iRst) begin
         state     <= IDLE;
         key_reg   <= '0;
         work_key  <= '0;
         key_cnt   <= '0;
         msg_cnt   <= '0;
         idx       <= '0;
         mode_q    <= 1'b0;
         key_ready <= 1'b0;
         s1        <= '0;
         s2        <= '0;
      end else if (iEn) begin
         state     <= state_nx;
         key_reg   <= key_reg_nx;
         work_key  <= work_key_nx;
         key_cnt   <= key_cnt_nx;
         msg_cnt   <= msg_cnt_nx;
         idx       <= idx_nx;
         mode_q    <= mode_nx;
         key_ready <= key_ready_nx;
         s1        <= s1_nx;
         s2        <= s2_nx;
      end
   end

   // A beat is presented only on enabled cycles, which are also the cycles it leaves stage 2.
   assign oData_out  = s2.data;
   assign oValid     = s2.valid & iEn;
   assign oStart     = s2.valid & s2.first & iEn;
   assign oEnd       = s2.valid & s2.last & iEn;
   assign oKey_ready = key_ready;
   assign oBusy      = (state == STREAM) || (state == DRAIN) || s1.valid || s2.valid;

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Self-checking bench for xor_stream_cipher (KEY_BITS=32, DATA_W=8, MAX_MSG_BITS=64).
module tb_xor_stream_cipher;

   logic       iClk, iRst, iEn, iMode, iLoad_key, iLoad_msg;
   logic [7:0] iData_in, oData_out;
   logic       oValid, oStart, oEnd, oKey_ready, oBusy;

   int checks   = 0;
   int failures = 0;

   // Per-cycle vector: {en lk lm md}, data in, {valid start end key_ready busy}, data out.
   typedef struct packed {
      logic       en;
      logic       lk;
      logic       lm;
      logic       md;
      logic [7:0] din;
      logic       v;
      logic       s;
      logic       e;
      logic       kr;
      logic       busy;
      logic [7:0] d;
   } vec_t;

   vec_t       vecs [13];
   logic [9:0] out_q [$];
   logic [9:0] exp_q [$];

   xor_stream_cipher #(.KEY_BITS(32), .DATA_W(8), .MAX_MSG_BITS(64)) dut (
      .iClk(iClk), .iRst(iRst), .iEn(iEn), .iMode(iMode), .iData_in(iData_in),
      .iLoad_key(iLoad_key), .iLoad_msg(iLoad_msg), .oData_out(oData_out),
      .oValid(oValid), .oStart(oStart), .oEnd(oEnd), .oKey_ready(oKey_ready), .oBusy(oBusy)
   );

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Record every presented output beat as {data, start, end}.
   always @(negedge iClk) if (oValid === 1'b1) out_q.push_back({oData_out, oStart, oEnd});

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Apply inputs just after a rising edge; return at the following falling edge.
   task automatic step(input logic rst, input logic en, input logic lk, input logic lm,
                       input logic md, input logic [7:0] d);
      @(posedge iClk); #1;
      iRst = rst; iEn = en; iLoad_key = lk; iLoad_msg = lm; iMode = md; iData_in = d;
      @(negedge iClk);
   endtask

   task automatic beat(input logic lk, input logic lm, input logic md, input logic [7:0] d);
      step(1'b0, 1'b1, lk, lm, md, d);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic check_q(input string name);
      check({name, " count"}, out_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++)
         check($sformatf("%s beat%0d {d,s,e}", name, i), {22'd0, out_q[i]}, {22'd0, exp_q[i]});
      out_q.delete();
      exp_q.delete();
   endtask

   initial begin
      iRst = 1'b1; iEn = 1'b0; iMode = 1'b0; iLoad_key = 1'b0; iLoad_msg = 1'b0; iData_in = 8'h00;

      // Key A5 5A 0F F0, then message 00 FF 00 FF 11 in repeating mode.
      vecs[0]  = {4'b1100, 8'hA5, 5'b00000, 8'h00};
      vecs[1]  = {4'b1100, 8'h5A, 5'b00000, 8'h00};
      vecs[2]  = {4'b1100, 8'h0F, 5'b00000, 8'h00};
      vecs[3]  = {4'b1100, 8'hF0, 5'b00000, 8'h00};
      vecs[4]  = {4'b1000, 8'h00, 5'b00010, 8'h00};
      vecs[5]  = {4'b1010, 8'h00, 5'b00010, 8'h00};
      vecs[6]  = {4'b1010, 8'hFF, 5'b00011, 8'h00};
      vecs[7]  = {4'b1010, 8'h00, 5'b11011, 8'hA5};
      vecs[8]  = {4'b1010, 8'hFF, 5'b10011, 8'hA5};
      vecs[9]  = {4'b1010, 8'h11, 5'b10011, 8'h0F};
      vecs[10] = {4'b1000, 8'h00, 5'b10011, 8'h0F};
      vecs[11] = {4'b1000, 8'h00, 5'b10111, 8'hB4};
      vecs[12] = {4'b1000, 8'h00, 5'b00010, 8'h00};

      // Reset (held with iEn=0 to show it overrides the enable).
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      check("reset data", oData_out, 8'h00);
      check("reset valid", oValid, 1'b0);
      check("reset start", oStart, 1'b0);
      check("reset end", oEnd, 1'b0);
      check("reset key_ready", oKey_ready, 1'b0);
      check("reset busy", oBusy, 1'b0);

      // Basic encrypt, cycle by cycle.
      for (int i = 0; i < 13; i++) begin
         step(1'b0, vecs[i].en, vecs[i].lk, vecs[i].lm, vecs[i].md, vecs[i].din);
         check($sformatf("vec%0d valid", i), oValid, vecs[i].v);
         check($sformatf("vec%0d start", i), oStart, vecs[i].s);
         check($sformatf("vec%0d end", i), oEnd, vecs[i].e);
         check($sformatf("vec%0d key_ready", i), oKey_ready, vecs[i].kr);
         check($sformatf("vec%0d busy", i), oBusy, vecs[i].busy);
         if (vecs[i].v) check($sformatf("vec%0d data", i), oData_out, vecs[i].d);
      end
      out_q.delete();

      // Rolling key: mode taken from beat 1 only, 8 beats hit the length limit.
      for (int i = 0; i < 8; i++) beat(1'b0, 1'b1, (i == 0), 8'h00);
      beat(1'b0, 1'b0, 1'b0, 8'h00);
      idle(3);
      exp_q = '{{8'hA5,2'b10}, {8'h5A,2'b00}, {8'h0F,2'b00}, {8'hF0,2'b00},
                {8'h4A,2'b00}, {8'hB4,2'b00}, {8'h1F,2'b00}, {8'hE1,2'b01}};
      check_q("rolling");

      // Length limit: 12 beats offered, 8 accepted, busy until iLoad_msg falls.
      for (int i = 0; i < 12; i++) beat(1'b0, 1'b1, 1'b0, 8'h00);
      check("limit busy in drain", oBusy, 1'b1);
      beat(1'b0, 1'b0, 1'b0, 8'h00);
      check("limit busy on release", oBusy, 1'b1);
      idle(2);
      check("limit busy after drain", oBusy, 1'b0);
      exp_q = '{{8'hA5,2'b10}, {8'h5A,2'b00}, {8'h0F,2'b00}, {8'hF0,2'b00},
                {8'hA5,2'b00}, {8'h5A,2'b00}, {8'h0F,2'b00}, {8'hF0,2'b01}};
      check_q("limit");

      // Single-beat message: start and end together.
      beat(1'b0, 1'b1, 1'b0, 8'h12);
      idle(4);
      exp_q = '{{8'hB7,2'b11}};
      check_q("single");

      // Key collision at message beat 3; that beat becomes key byte 1 of 11 22 33 44.
      beat(1'b0, 1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b1, 1'b0, 8'h00);
      beat(1'b1, 1'b1, 1'b0, 8'h11);
      beat(1'b1, 1'b0, 1'b0, 8'h22);
      check("collision key_ready cleared", oKey_ready, 1'b0);
      beat(1'b1, 1'b0, 1'b0, 8'h33);
      beat(1'b1, 1'b0, 1'b0, 8'h44);
      idle(1);
      check("collision new key ready", oKey_ready, 1'b1);
      exp_q = '{{8'hA5,2'b10}, {8'h5A,2'b01}};
      check_q("collision");
      beat(1'b0, 1'b1, 1'b0, 8'h00);
      idle(4);
      exp_q = '{{8'h11,2'b11}};
      check_q("new key");

      // Enable low for 3 cycles mid-message.
      beat(1'b0, 1'b1, 1'b0, 8'h01);
      beat(1'b0, 1'b1, 1'b0, 8'h02);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
         check($sformatf("disable valid %0d", i), oValid, 1'b0);
         check($sformatf("disable busy %0d", i), oBusy, 1'b1);
      end
      beat(1'b0, 1'b1, 1'b0, 8'h03);
      beat(1'b0, 1'b1, 1'b0, 8'h04);
      beat(1'b0, 1'b1, 1'b0, 8'h05);
      beat(1'b0, 1'b0, 1'b0, 8'h00);
      idle(3);
      exp_q = '{{8'h10,2'b10}, {8'h20,2'b00}, {8'h30,2'b00}, {8'h40,2'b00}, {8'h14,2'b01}};
      check_q("disable");

      // Reset mid-message, then a message with no key loaded.
      beat(1'b0, 1'b1, 1'b0, 8'h00);
      beat(1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      check("midreset data", oData_out, 8'h00);
      check("midreset valid", oValid, 1'b0);
      check("midreset start", oStart, 1'b0);
      check("midreset end", oEnd, 1'b0);
      check("midreset key_ready", oKey_ready, 1'b0);
      check("midreset busy", oBusy, 1'b0);
      out_q.delete();
      for (int i = 0; i < 4; i++) beat(1'b0, 1'b1, 1'b0, 8'h5C);
      idle(3);
      check("nokey busy", oBusy, 1'b0);
      check("nokey key_ready", oKey_ready, 1'b0);
      check_q("nokey");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
